// File: rtl/reg_file_sb.sv
// Integer register file: 2 combinational read ports, 2 write ports (load port wins) and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module reg_file_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            res,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  input  logic            clr0,
  input  logic            clr1,
  output logic            any_busy
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_ff @(posedge clk) begin
    if (!res) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      // Port 1 is assigned last so a same-address load writeback wins.
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
      busy <= busy_next;
    end
  end

  // A new issue overrides a same-cycle retire so the newer producer stays tracked.
  always_comb begin
    set_vec   = '0;
    clr_vec   = '0;
    if (iss_v) set_vec = NREG'(1) << iss_rd;
    if (we0 && clr0) clr_vec = clr_vec | (NREG'(1) << wa0);
    if (we1 && clr1) clr_vec = clr_vec | (NREG'(1) << wa1);
    busy_next = ((busy & ~clr_vec) | set_vec) & ~NREG'(1);
  end

  assign any_busy = |busy;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 != '0) begin
      if (we1 && wa1 == ra1)      rd1 = wd1;
      else if (we0 && wa0 == ra1) rd1 = wd0;
    end
    rd2 = regs[ra2];
    if (ra2 != '0) begin
      if (we1 && wa1 == ra2)      rd2 = wd1;
      else if (we0 && wa0 == ra2) rd2 = wd0;
    end
  end

  always_comb begin
    busy1 = busy[ra1];
    busy2 = busy[ra2];
    if (((we0 && clr0 && wa0 == ra1) || (we1 && clr1 && wa1 == ra1)) &&
        !(iss_v && iss_rd == ra1))
      busy1 = 1'b0;
    if (((we0 && clr0 && wa0 == ra2) || (we1 && clr1 && wa1 == ra2)) &&
        !(iss_v && iss_rd == ra2))
      busy2 = 1'b0;
  end
`else
  assign rd1   = regs[ra1];
  assign rd2   = regs[ra2];
  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_BUSY1 = 2, SEL_BUSY2 = 3, SEL_ANY = 4;

  logic            clk = 1'b0;
  logic            res;
  logic [AW-1:0]   ra1, ra2, wa0, wa1, iss_rd;
  logic [XLEN-1:0] rd1, rd2, wd0, wd1;
  logic            busy1, busy2, we0, we1, iss_v, clr0, clr1, any_busy;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .res(res), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .iss_v(iss_v), .iss_rd(iss_rd),
    .clr0(clr0), .clr1(clr1), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic a_we0, input logic [AW-1:0] a_wa0,
                               input logic [XLEN-1:0] a_wd0, input logic a_clr0,
                               input logic a_we1, input logic [AW-1:0] a_wa1,
                               input logic [XLEN-1:0] a_wd1, input logic a_clr1,
                               input logic a_iss, input logic [AW-1:0] a_rd);
    we0 = a_we0; wa0 = a_wa0; wd0 = a_wd0; clr0 = a_clr0;
    we1 = a_we1; wa1 = a_wa1; wd1 = a_wd1; clr1 = a_clr1;
    iss_v = a_iss; iss_rd = a_rd;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_RD1:   return rd1;
      SEL_RD2:   return rd2;
      SEL_BUSY1: return {31'b0, busy1};
      SEL_BUSY2: return {31'b0, busy2};
      default:   return {31'b0, any_busy};
    endcase
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = sample(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    res = 1'b0; ra1 = '0; ra2 = '0;
    idle();
    tick();
    res = 1'b1;
    ra1 = 5'd3;
    push_exp("reset_rd1", SEL_RD1, 32'h0);
    push_exp("reset_any_busy", SEL_ANY, 32'h0);
    checkOutput();

    // Fill every register with ones and mark one busy.
    for (int r = 1; r < NREG; r++) begin
      applyStimulus(1, AW'(r), 32'hFFFF_FFFF, 0, 0, 0, 0, 0, (r == 1), 5'd4);
      tick();
    end
    idle();
    ra1 = 5'd31; ra2 = 5'd4;
    push_exp("fill_rd1_r31", SEL_RD1, 32'hFFFF_FFFF);
    push_exp("fill_busy2_r4", SEL_BUSY2, 32'h1);
    push_exp("fill_any_busy", SEL_ANY, 32'h1);
    checkOutput();

    // Reset must override writes and issues in the same cycle.
    res = 1'b0;
    applyStimulus(1, 5'd2, 32'h1234, 0, 1, 5'd3, 32'h5678, 0, 1, 5'd6);
    tick();
    res = 1'b1;
    idle();
    for (int a = 0; a < NREG; a++) begin
      ra1 = AW'(a); ra2 = AW'(NREG - 1 - a);
      push_exp($sformatf("post_reset_rd1_r%0d", a), SEL_RD1, 32'h0);
      push_exp($sformatf("post_reset_rd2_r%0d", NREG - 1 - a), SEL_RD2, 32'h0);
      checkOutput();
    end
    push_exp("post_reset_any_busy", SEL_ANY, 32'h0);
    checkOutput();

    // Register 0 ignores writes and issues.
    applyStimulus(1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 5'd0);
    tick();
    idle();
    ra1 = 5'd0;
    push_exp("x0_rd1", SEL_RD1, 32'h0);
    push_exp("x0_busy1", SEL_BUSY1, 32'h0);
    push_exp("x0_any_busy", SEL_ANY, 32'h0);
    checkOutput();

    // Collision on r5: load port wins.
    applyStimulus(1, 5'd5, 32'h11, 0, 1, 5'd5, 32'h22, 0, 0, 0);
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd5;
    push_exp("collide_rd1_r5", SEL_RD1, 32'h22);
    push_exp("collide_rd2_r5", SEL_RD2, 32'h22);
    checkOutput();

    // Independent writes; value not visible before the edge without forwarding.
    applyStimulus(1, 5'd6, 32'h66, 0, 1, 5'd10, 32'hAA, 0, 0, 0);
    ra1 = 5'd6; ra2 = 5'd10;
`ifdef REGFILE_BYPASS_EN
    push_exp("pre_edge_rd1_r6", SEL_RD1, 32'h66);
`else
    push_exp("pre_edge_rd1_r6", SEL_RD1, 32'h0);
`endif
    checkOutput();
    tick();
    idle();
    push_exp("dual_rd1_r6", SEL_RD1, 32'h66);
    push_exp("dual_rd2_r10", SEL_RD2, 32'hAA);
    checkOutput();

    // Scoreboard on r7: issue, then retire together with a re-issue, then retire alone.
    ra1 = 5'd7;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    push_exp("sb_same_cycle_issue_busy1", SEL_BUSY1, 32'h0);
    checkOutput();
    tick();
    idle();
    push_exp("sb_c1_busy1", SEL_BUSY1, 32'h1);
    push_exp("sb_c1_any_busy", SEL_ANY, 32'h1);
    checkOutput();
    tick();
    tick();
    applyStimulus(1, 5'd7, 32'h70, 1, 0, 0, 0, 0, 1, 5'd7);
    push_exp("sb_c3_clr_and_issue_now", SEL_BUSY1, 32'h1);
    checkOutput();
    tick();
    applyStimulus(1, 5'd7, 32'h77, 1, 0, 0, 0, 0, 0, 0);
    push_exp("sb_c4_busy_kept", SEL_ANY, 32'h1);
`ifdef REGFILE_BYPASS_EN
    push_exp("sb_c4_clr_now_busy1", SEL_BUSY1, 32'h0);
`else
    push_exp("sb_c4_clr_now_busy1", SEL_BUSY1, 32'h1);
`endif
    checkOutput();
    tick();
    idle();
    push_exp("sb_c5_busy1", SEL_BUSY1, 32'h0);
    push_exp("sb_c5_any_busy", SEL_ANY, 32'h0);
    push_exp("sb_c5_rd1_r7", SEL_RD1, 32'h77);
    checkOutput();

    // clr1 without we1 is ignored; port 0 write without clr0 keeps r12 busy.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
    tick();
    applyStimulus(1, 5'd12, 32'hC0, 0, 0, 5'd8, 32'h0, 1, 0, 0);
    tick();
    idle();
    ra1 = 5'd12; ra2 = 5'd8;
    push_exp("sb_noclr_busy1_r12", SEL_BUSY1, 32'h1);
    push_exp("sb_clr_no_we_busy2_r8", SEL_BUSY2, 32'h1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 1, 5'd8, 32'h88, 1, 0, 0);
    tick();
    idle();
    push_exp("sb_clr1_busy2_r8", SEL_BUSY2, 32'h0);
    push_exp("sb_clr1_busy1_r12", SEL_BUSY1, 32'h1);
    push_exp("sb_clr1_rd2_r8", SEL_RD2, 32'h88);
    checkOutput();
    applyStimulus(1, 5'd12, 32'hC1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    push_exp("sb_drain_any_busy", SEL_ANY, 32'h0);
    checkOutput();

    // Forwarding on r9, priority on r11, nothing forwarded to r0.
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 32'hCAFE, 0, 0, 0);
    ra2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push_exp("bypass_rd2_r9", SEL_RD2, 32'hCAFE);
`else
    push_exp("bypass_rd2_r9", SEL_RD2, 32'h0);
`endif
    checkOutput();
    tick();
    idle();
    push_exp("bypass_next_rd2_r9", SEL_RD2, 32'hCAFE);
    checkOutput();
    applyStimulus(1, 5'd11, 32'hB0, 0, 1, 5'd11, 32'hB1, 0, 0, 0);
    ra1 = 5'd11;
`ifdef REGFILE_BYPASS_EN
    push_exp("bypass_prio_rd1_r11", SEL_RD1, 32'hB1);
`else
    push_exp("bypass_prio_rd1_r11", SEL_RD1, 32'h0);
`endif
    checkOutput();
    tick();
    applyStimulus(1, 5'd0, 32'h5555, 0, 1, 5'd0, 32'h6666, 0, 0, 0);
    ra1 = 5'd0;
    push_exp("bypass_r0_rd1", SEL_RD1, 32'h0);
    checkOutput();
    tick();
    idle();
    ra2 = 5'd11;
    push_exp("prio_next_rd2_r11", SEL_RD2, 32'hB1);
    push_exp("r0_after_write_rd1", SEL_RD1, 32'h0);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the CPU core: 2 async read ports, 2 sync write ports (ALU writeback, load writeback) and a per-register busy scoreboard.
- Lets the decode stage detect RAW hazards on in-flight destinations.
- Successor to the single-write-port 32x32 file; the register at address 0 stays hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of 2, >= 2.
- AW, $clog2(NREG), address width (derived; not overridden).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- res  in  1  synchronous reset, active-low; sampled on rising clk.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  XLEN  read data, port 1 (combinational).
- rd2  out  XLEN  read data, port 2 (combinational).
- busy1  out  1  scoreboard bit of ra1 (combinational).
- busy2  out  1  scoreboard bit of ra2 (combinational).
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- iss_v  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination of the issued instruction.
- clr0  in  1  write on port 0 retires its producer: clear busy[wa0].
- clr1  in  1  same as clr0, for port 1 / busy[wa1].
- any_busy  out  1  OR of all busy bits (drain/flush indicator).

Behaviour:
- Reset: res==0 at a rising edge sets all NREG registers to 0 and all busy bits to 0. Overrides every write, issue and clear in that cycle. After the reset edge, any_busy=0 and rd1/rd2 read 0 for every address.
- Address 0: writes ignored, reads return 0, busy[0] never set (iss_v with iss_rd==0 is a no-op), busy1/busy2 for address 0 always read 0.
- Write latency: 1 cycle. Data written at edge N is visible on rd* after edge N.
- Same-address writes: we0 and we1 both set with wa0==wa1!=0 → wd1 wins (load port has priority).
- Read ports: rd1 = REG[ra1], rd2 = REG[ra2]; purely combinational; both ports may address the same register.
- Scoreboard, per register r!=0, evaluated each edge:
  - set = iss_v && iss_rd==r.
  - clear = (we0 && clr0 && wa0==r) || (we1 && clr1 && wa1==r).
  - set && clear → busy stays 1 (the new producer wins).
  - clear only → 0; set only → 1; neither → hold.
  - clr0/clr1 are ignored when the matching we* is 0.
- Issuing to an already-busy register is legal; the bit stays 1. No counting, single-producer model.
- busy1/busy2 reflect the registered busy bits. Same-cycle iss_v/clr* do not affect them.
- any_busy is registered-state derived (OR of busy bits, no same-cycle terms).
- No X propagation: unwritten registers are defined as 0 from reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- With the macro defined, write-to-read forwarding is enabled:
  - rd1 returns wd1 if we1 && wa1==ra1 && ra1!=0; else wd0 if we0 && wa0==ra1 && ra1!=0; else REG[ra1]. Same for rd2.
  - busy1/busy2 are additionally forced to 0 when a same-cycle write with its clr* targets that address and no same-cycle iss_v targets it.
- Without the macro: reads see only registered state. A value written at edge N is readable only after edge N. No forwarding logic is synthesised.

Test Plan:
- Reset: write all regs to 0xFFFFFFFF, then res=0 for 1 cycle → every rd1/rd2 = 0, any_busy=0.
- x0: we0=1, wa0=0, wd0=0xDEADBEEF and iss_v=1, iss_rd=0 → rd1(ra1=0)=0, busy1=0, any_busy=0.
- Dual write collision: we0=we1=1, wa0=wa1=5, wd0=0x11, wd1=0x22 → next cycle rd1(ra1=5)=0x22.
- Scoreboard: iss_v to r7 at cycle 0 → busy1(ra1=7)=1 at cycle 1. At cycle 3, we0=1, wa0=7, clr0=1, with iss_v to r7 the same cycle → busy stays 1. Clear again at cycle 4 with no issue → busy1=0 at cycle 5.
- Bypass: we1=1, wa1=9, wd1=0xCAFE with ra2=9 the same cycle → rd2=0xCAFE with REGFILE_BYPASS_EN defined, old value (0 after reset) without it. Both builds read 0xCAFE next cycle.
